// File: rtl/hex_scan_ctrl_pkg.sv
// Shared constants, segment table and FSM encoding for the HEX scan controller.
package hex_scan_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [SEG_W-1:0]   SEG_BLANK = 7'b1111111;
  localparam logic [DIGIT_W-1:0] BCD_MAX   = 4'd9;

  // Active-low g..a patterns, entry n is the pattern for digit n.
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes go dark.
module bcd_seg_decode
  import hex_scan_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] code_i,
  output logic [SEG_W-1:0]   seg_o
);

  // Table lookup with blanking for codes above 9.
  always_comb begin
    seg_o = SEG_BLANK;
    if (code_i <= BCD_MAX) begin
      seg_o = SEG_TABLE[code_i];
    end
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Six-digit HEX bank controller: shadow/active digit sets with frame-aligned
// commit, round-robin scan through one shared decoder, registered segments.
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned PTR_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [PTR_W-1:0]        wr_addr,
  input  logic [DIGIT_W-1:0]      wr_data,
  output logic                    wr_ready,
  input  logic                    commit,
  input  logic                    lzb_en,
  input  logic                    blank_all,
  output logic                    frame_done,
  output logic [SEG_W*NUM_DIGITS-1:0] hex
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_DIGITS - 1);

  state_e state_q, state_d;

  logic [PTR_W-1:0]                      ptr_q, ptr_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    active_q, active_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]      hex_q, hex_d;
  logic                                  wr_ready_q, frame_done_q;

  logic                  at_last_c;
  logic                  shadow_we_c;
  logic                  copy_c;
  logic [NUM_DIGITS-1:0] zero_from_c;
  logic                  lz_blank_c;
  logic [SEG_W-1:0]      scan_seg_c;
  logic [SEG_W-1:0]      scan_out_c;

  assign at_last_c = (ptr_q == LAST_PTR);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a commit waits for the frame boundary unless already there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit && !at_last_c) state_d = PENDING;
      PENDING: if (at_last_c)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: shadow write enable and shadow-to-active copy strobe.
  always_comb begin
    shadow_we_c = 1'b0;
    copy_c      = 1'b0;
    case (state_q)
      IDLE: begin
        shadow_we_c = wr_en && (32'(wr_addr) < NUM_DIGITS);
        copy_c      = commit && at_last_c;
      end
      PENDING: begin
        copy_c = at_last_c;
      end
      default: begin
        shadow_we_c = 1'b0;
        copy_c      = 1'b0;
      end
    endcase
  end

  // Per-digit flag: this digit and every digit above it are zero.
  always_comb begin
    zero_from_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      zero_from_c[PTR_W'(k)] = 1'b1;
      for (int j = k; j < int'(NUM_DIGITS); j++) begin
        if (active_q[PTR_W'(j)] != '0) zero_from_c[PTR_W'(k)] = 1'b0;
      end
    end
  end

  bcd_seg_decode u_dec (
    .code_i (active_q[ptr_q]),
    .seg_o  (scan_seg_c)
  );

  // Blanking priority for the digit under the scan pointer.
  always_comb begin
    lz_blank_c = lzb_en && (ptr_q != '0) && zero_from_c[ptr_q];
    scan_out_c = scan_seg_c;
    if (blank_all || lz_blank_c) scan_out_c = SEG_BLANK;
  end

  // Datapath next values: write merges before copy so a same-cycle write is committed.
  always_comb begin
    shadow_d = shadow_q;
    if (shadow_we_c) shadow_d[wr_addr] = wr_data;
    active_d = copy_c ? shadow_d : active_q;
    hex_d         = hex_q;
    hex_d[ptr_q]  = scan_out_c;
    ptr_d         = at_last_c ? '0 : ptr_q + PTR_W'(1);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      hex_q        <= {NUM_DIGITS{SEG_BLANK}};
      wr_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      hex_q        <= hex_d;
      wr_ready_q   <= (state_d == IDLE);
      frame_done_q <= at_last_c;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign frame_done = frame_done_q;
  assign hex        = hex_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Self-checking bench for hex_scan_ctrl: per-cycle model compare plus literal pins.
module tb_hex_scan_ctrl;

  localparam int ND = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ready;
  logic        commit;
  logic        lzb_en;
  logic        blank_all;
  logic        frame_done;
  logic [41:0] hex;

  int checks   = 0;
  int failures = 0;

  hex_scan_ctrl #(.NUM_DIGITS(6), .PTR_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .commit     (commit),
    .lzb_en     (lzb_en),
    .blank_all  (blank_all),
    .frame_done (frame_done),
    .hex        (hex)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0] m_shadow [ND];
  logic [3:0] m_active [ND];
  logic [6:0] m_hex    [ND];
  int         m_ptr;
  bit         m_pend, m_ready, m_fd, m_valid;

  function automatic logic [6:0] exp_seg(int k);
    bit upper_zero = 1'b1;
    for (int j = k; j < ND; j++) if (m_active[j] != 4'd0) upper_zero = 1'b0;
    if (blank_all) return 7'h7F;
    if (lzb_en && k > 0 && upper_zero) return 7'h7F;
    if (m_active[k] > 4'd9) return 7'h7F;
    return seg_tbl[m_active[k]];
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] ns [ND];
    bit pend_n;
    if (rst) begin
      for (int k = 0; k < ND; k++) begin
        m_shadow[k] <= 4'd0;
        m_active[k] <= 4'd0;
        m_hex[k]    <= 7'h7F;
      end
      m_ptr   <= 0;
      m_pend  <= 1'b0;
      m_ready <= 1'b1;
      m_fd    <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      ns = m_shadow;
      if (!m_pend && wr_en && int'(wr_addr) < ND) ns[wr_addr] = wr_data;
      m_hex[m_ptr] <= exp_seg(m_ptr);
      pend_n = m_pend;
      if (m_ptr == ND - 1 && (m_pend || commit)) begin
        m_active <= ns;
        pend_n = 1'b0;
      end else if (commit) begin
        pend_n = 1'b1;
      end
      m_shadow <= ns;
      m_pend   <= pend_n;
      m_ready  <= !pend_n;
      m_fd     <= (m_ptr == ND - 1);
      m_ptr    <= (m_ptr + 1) % ND;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [41:0] exp_hex;
    if (m_valid) begin
      for (int k = 0; k < ND; k++) exp_hex[7*k +: 7] = m_hex[k];
      checks = checks + 3;
      if (hex !== exp_hex) begin
        failures = failures + 1;
        $display("FAIL model_hex t=%0t got=%h exp=%h", $time, hex, exp_hex);
      end
      if (wr_ready !== m_ready) begin
        failures = failures + 1;
        $display("FAIL model_wr_ready t=%0t got=%b exp=%b", $time, wr_ready, m_ready);
      end
      if (frame_done !== m_fd) begin
        failures = failures + 1;
        $display("FAIL model_frame_done t=%0t got=%b exp=%b", $time, frame_done, m_fd);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align(input int target);
    for (int i = 0; i < 20 && m_ptr != target; i++) step();
    chk("align_ptr", 42'(m_ptr), 42'(target));
  endtask

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_ZERO  = {6{7'h40}};

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; lzb_en = 1'b0; blank_all = 1'b0;
    step(2);
    chk("reset_hex", hex, ALL_BLANK);
    chk("reset_wr_ready", 42'(wr_ready), 42'd1);
    chk("reset_frame_done", 42'(frame_done), 42'd0);
    rst = 1'b0;

    // First frame after reset: all digits zero.
    step(6);
    chk("first_frame_hex", hex, ALL_ZERO);
    chk("first_frame_done", 42'(frame_done), 42'd1);

    // Load 1..6 and commit aligned to ptr 0.
    for (int i = 0; i < ND; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 1);
      step();
    end
    wr_en = 1'b0;
    chk("shadow_not_shown", hex, ALL_ZERO);
    commit = 1'b1; step(); commit = 1'b0;
    chk("pending_ready_low", 42'(wr_ready), 42'd0);
    step(4);
    chk("pending_ready_still_low", 42'(wr_ready), 42'd0);
    step();
    chk("ready_after_copy", 42'(wr_ready), 42'd1);
    chk("no_partial_update", hex, ALL_ZERO);
    step(6);
    chk("hex_123456", hex, {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});

    // Leading-zero blanking on 000042.
    lzb_en = 1'b1;
    for (int i = 0; i < ND; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i);
      wr_data = (i == 0) ? 4'd2 : (i == 1) ? 4'd4 : 4'd0;
      step();
    end
    wr_en = 1'b0;
    commit = 1'b1; step(); commit = 1'b0;
    step(14);
    chk("lzb_000042", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});

    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd0; step();
    wr_addr = 3'd1; step();
    wr_en = 1'b0;
    commit = 1'b1; step(); commit = 1'b0;
    step(14);
    chk("lzb_000000", hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    lzb_en = 1'b0;

    // Non-BCD code blanks; out-of-range address has no effect.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'd12; commit = 1'b1; step();
    wr_en = 1'b0; commit = 1'b0;
    step(14);
    chk("code12_blank", hex, {7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h40});
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'd5; step();
    wr_en = 1'b0;
    commit = 1'b1; step(); commit = 1'b0;
    step(14);
    chk("addr7_ignored", hex, {7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h40});

    // Write+commit together, then write+commit while pending.
    align(1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd9; commit = 1'b1; step();
    wr_addr = 3'd1; wr_data = 4'd8; step();
    wr_en = 1'b0; commit = 1'b0;
    step(14);
    chk("same_cycle_write", hex, {7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h10});
    commit = 1'b1; step(); commit = 1'b0;
    step(14);
    chk("pending_write_dropped", hex, {7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h10});

    // Blank-all override.
    blank_all = 1'b1; step(6);
    chk("blank_all", hex, ALL_BLANK);
    blank_all = 1'b0; step(6);
    chk("blank_all_release", hex, {7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h10});

    // Reset while pending drops the commit and clears both digit sets.
    align(1);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd3; commit = 1'b1; step();
    wr_en = 1'b0; commit = 1'b0;
    chk("pre_reset_pending", 42'(wr_ready), 42'd0);
    rst = 1'b1; step();
    chk("midreset_hex", hex, ALL_BLANK);
    chk("midreset_ready", 42'(wr_ready), 42'd1);
    chk("midreset_frame_done", 42'(frame_done), 42'd0);
    rst = 1'b0;
    step(6);
    chk("active_cleared", hex, ALL_ZERO);
    commit = 1'b1; step(); commit = 1'b0;
    step(14);
    chk("shadow_cleared", hex, ALL_ZERO);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Display controller for the DE10-Lite HEX0..HEX5 active-low seven-segment bank.
- Holds six BCD digits in a shadow register file and commits them atomically to an active set.
- Time-shares one combinational BCD-to-segment decoder across all six displays, round-robin, one digit per clock.
- Drives registered, glitch-free, active-low segment outputs.
- Sits between the user/counter logic that produces digit values and the board HEX pins.

Parameters:
- NUM_DIGITS, 6, number of displays scanned (2..8).
- PTR_W, 3, scan-pointer/address width, must satisfy 2^PTR_W >= NUM_DIGITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  shadow write request.
- wr_addr  in  PTR_W  digit index; 0 = HEX0, rightmost.
- wr_data  in  4  BCD code.
- wr_ready  out  1  shadow write accepted when wr_en && wr_ready.
- commit  in  1  single-cycle request to copy shadow to active.
- lzb_en  in  1  leading-zero blanking enable.
- blank_all  in  1  force all displays dark.
- frame_done  out  1  one-cycle pulse when the scan pointer wraps.
- hex  out  7*NUM_DIGITS  segments; hex[7k+6:7k] = HEXk, active-low (0 = segment lit).

Behaviour:
- Reset (synchronous, active-high) values:
  - shadow and active digits = 0; scan ptr = 0; state = IDLE.
  - wr_ready = 1; frame_done = 0; every hex field = 7'b1111111 (blank).
- Scan:
  - ptr increments every cycle and wraps NUM_DIGITS-1 -> 0.
  - The decoder is fed active[ptr]; its result is registered into hex field ptr at the next edge. All other fields hold.
  - frame_done = 1 in the cycle after ptr was NUM_DIGITS-1.
- Segment encoding (active-low, bit 6..0 = g..a):
  - Codes 0..9 use the standard pattern, e.g. 0 -> 1000000, 8 -> 0000000.
  - Codes 10..15 are masked by the controller to blank (1111111).
- Blanking priority (highest first):
  1. blank_all = 1 -> blank.
  2. lzb_en = 1 and digit k is zero, k > 0, and all active digits above k are zero -> blank. Digit 0 is never zero-blanked.
  3. Otherwise the decoded pattern.
- Latency: an active-digit change reaches its hex field within NUM_DIGITS cycles. blank_all / lzb_en changes take full effect within NUM_DIGITS cycles; no combinational path to hex.
- Write/commit state machine:
  - IDLE: wr_ready = 1. A write to wr_addr < NUM_DIGITS updates shadow at the edge; wr_addr >= NUM_DIGITS is accepted with no effect. commit = 1 -> PENDING.
  - PENDING: wr_ready = 0; wr_en ignored; a further commit is ignored. At the edge where ptr == NUM_DIGITS-1, shadow copies to active and state -> IDLE. The new frame therefore starts at ptr 0 with the new data, so no torn frames.
- Simultaneous wr_en + commit in IDLE: the write lands in shadow first and is included in the commit.
- Commit arriving while ptr == NUM_DIGITS-1: copy happens at that same edge, with zero wait.
- Reset mid-PENDING: the pending commit is dropped and the shadow contents are lost.

Decomposition:
- Shared package holds:
  - SEG_BLANK = 7'b1111111.
  - BCD_MAX = 9.
  - The segment pattern constant table for 0..9.
  - The state encoding IDLE / PENDING.
- One natural sub-module: bcd_seg_decode, a 4-in/7-out combinational active-low decoder. It is instantiated once and shared by the scan mux.

Test Plan:
- Reset hold 2 cycles -> all hex = 7F, wr_ready = 1, frame_done = 0. After release, frame_done pulses every 6 cycles; after the first frame all hex = 40 (digit 0).
- Write digits 1,2,3,4,5,6 to addr 0..5, then commit -> wr_ready low until the ptr==5 edge. The next frame shows HEX0 = 79, HEX1 = 24, HEX2 = 30, HEX3 = 19, HEX4 = 12, HEX5 = 02, with no earlier partial update.
- Active = 000042 with lzb_en = 1 -> HEX5..HEX2 = 7F, HEX1 = 19, HEX0 = 24. Active = 000000 -> only HEX0 = 40.
- Write code 12 to addr 3 and commit -> HEX3 = 7F. Write addr 7 -> no shadow change.
- Commit with wr_en in the same cycle (addr 0, data 9), then another commit while PENDING -> 9 is shown on HEX0, exactly one copy occurs, and the PENDING writes are dropped.
- Assert rst while PENDING -> state IDLE, all hex = 7F next cycle, active and shadow = 0.
